// File: rtl/zp_pkg.sv
// zp_pkg: shared constants, tap indices and FSM state type for the zero-pad 3x3 window generator
package zp_pkg;
    localparam int KERNEL = 3;
    localparam int NTAPS = KERNEL * KERNEL;
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;
    typedef enum logic [1:0] {ZP_IDLE, ZP_RUN, ZP_DRAIN} zp_state_t;
endpackage

// File: rtl/zp_line_buffer.sv
// zp_line_buffer: two raster rows of history, read-before-write at one shared index per step
module zp_line_buffer #(
    parameter int DATA_W = 10,
    parameter int MAX_W = 112,
    parameter int AW = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1
);
    logic [DATA_W-1:0] row0 [MAX_W];
    logic [DATA_W-1:0] row1 [MAX_W];
    assign rd0 = row0[addr];
    assign rd1 = row1[addr];
    always_ff @(posedge clk) begin
        if (we) begin
            row1[addr] <= row0[addr];
            row0[addr] <= wdata;
        end
    end
endmodule

// File: rtl/zero_pad_window_gen.sv
// zero_pad_window_gen: streaming 3x3 window generator with pad=1 zero masking from internal row/col counters.
// Optional ZP_STRIDE2_EN adds i_stride2, which emits only even-row/even-col centred windows.
module zero_pad_window_gen
    import zp_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int MAX_W = 112,
    parameter int MAX_H = 112,
    parameter int DIM_W = $clog2(MAX_H + 2)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [DIM_W-1:0]        i_width,
    input  logic [DIM_W-1:0]        i_height,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [NTAPS*DATA_W-1:0] o_data,
    output logic [NTAPS-1:0]        o_sel,
    input  logic                    i_ready,
    output logic                    o_last,
`ifdef ZP_STRIDE2_EN
    input  logic                    i_stride2,
`endif
    output logic                    o_busy
);
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
    localparam logic [DIM_W-1:0] W_LIM = DIM_W'(MAX_W);
    localparam logic [DIM_W-1:0] H_LIM = DIM_W'(MAX_H);
    zp_state_t state;
    logic [DIM_W-1:0] width, height, vr, vc;
    logic stride2, stride_in;
    logic [DATA_W-1:0] win [NTAPS];
    logic [DATA_W-1:0] nxt [NTAPS];
    logic [DATA_W-1:0] rd0, rd1, pix;
    logic [NTAPS-1:0] sel;
    logic [NTAPS*DATA_W-1:0] masked;
    logic inj, out_free, step, emit, last_pos, start_ok;
    logic top_ok, bot_ok, left_ok, right_ok;
`ifdef ZP_STRIDE2_EN
    assign stride_in = i_stride2;
`else
    assign stride_in = 1'b0;
`endif
    assign start_ok = i_width != '0 && i_width <= W_LIM && i_height != '0 && i_height <= H_LIM;
    // Positions on the extra row/column feed zero and never consume an input pixel.
    assign inj = vr == height || vc == width;
    assign out_free = !o_valid || i_ready;
    assign o_ready = state == ZP_RUN && !inj && out_free;
    assign step = state == ZP_RUN && out_free && (inj || i_valid);
    assign pix = inj ? '0 : i_data;
    assign emit = step && vr != '0 && vc != '0 && (!stride2 || (vr[0] && vc[0]));
    assign last_pos = stride2 ? vr == ((height - ONE) | ONE) && vc == ((width - ONE) | ONE)
                              : vr == height && vc == width;
    assign top_ok = vr != ONE;
    assign bot_ok = vr != height;
    assign left_ok = vc != ONE;
    assign right_ok = vc != width;
    assign sel[TAP_TL] = top_ok & left_ok;
    assign sel[TAP_TC] = top_ok;
    assign sel[TAP_TR] = top_ok & right_ok;
    assign sel[TAP_ML] = left_ok;
    assign sel[TAP_MC] = 1'b1;
    assign sel[TAP_MR] = right_ok;
    assign sel[TAP_BL] = bot_ok & left_ok;
    assign sel[TAP_BC] = bot_ok;
    assign sel[TAP_BR] = bot_ok & right_ok;
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            nxt[r*KERNEL] = win[r*KERNEL+1];
            nxt[r*KERNEL+1] = win[r*KERNEL+2];
        end
        nxt[TAP_TR] = rd1;
        nxt[TAP_MR] = rd0;
        nxt[TAP_BR] = pix;
        masked = '0;
        for (int k = 0; k < NTAPS; k++) masked[k*DATA_W +: DATA_W] = sel[k] ? nxt[k] : '0;
    end
    zp_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W), .AW(DIM_W)) u_lb (
        .clk(i_clk),
        .we(step && vc != width),
        .addr(vc),
        .wdata(pix),
        .rd0(rd0),
        .rd1(rd1)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ZP_IDLE;
            width <= '0;
            height <= '0;
            vr <= '0;
            vc <= '0;
            stride2 <= 1'b0;
            o_valid <= 1'b0;
            o_last <= 1'b0;
            o_busy <= 1'b0;
            o_data <= '0;
            o_sel <= '0;
            for (int k = 0; k < NTAPS; k++) win[k] <= '0;
        end else begin
            if (state == ZP_IDLE && i_start && start_ok) begin
                state <= ZP_RUN;
                width <= i_width;
                height <= i_height;
                stride2 <= stride_in;
                vr <= '0;
                vc <= '0;
                o_busy <= 1'b1;
            end
            if (step) begin
                for (int k = 0; k < NTAPS; k++) win[k] <= nxt[k];
                vc <= vc == width ? '0 : vc + ONE;
                if (vc == width) begin
                    vr <= vr + ONE;
                    if (vr == height) state <= ZP_DRAIN;
                end
            end
            if (emit) begin
                o_valid <= 1'b1;
                o_last <= last_pos;
                o_data <= masked;
                o_sel <= sel;
            end else if (i_ready) begin
                o_valid <= 1'b0;
                o_last <= 1'b0;
            end
            if (state == ZP_DRAIN && out_free) begin
                state <= ZP_IDLE;
                o_busy <= 1'b0;
            end
        end
    end
endmodule
